// File: rtl/dzcpu_uop_sequencer.sv
// ---------------------------------------------------------------------------
// dzcpu_uop_sequencer
//
// Microcode sequencer for the dzcpu core. It fetches an opcode, maps it to a
// microflow start index through an external lookup table, then walks the
// microcode ROM one word per cycle until an end-of-flow (EOF) code retires
// the instruction. A "jump to CB flow" operation re-indexes through the CB
// table for prefixed opcodes.
//
// Optional feature (macro DZCPU_SEQ_IRQ_EN): when defined, an EOF that sees
// iIrqReq & iIme enters an IRQ state that acknowledges the interrupt and
// starts the interrupt-entry microflow at IRQ_FLOW_IDX. When undefined, the
// IRQ state does not exist and oIrqAck is tied low.
//
// Ports
//   iClock        clock, all state on rising edge
//   iReset        synchronous active-low reset
//   iMemData      memory byte (opcode in FETCH, CB sub-opcode during a flow)
//   iFetchValid   iMemData holds a valid opcode (FETCH only)
//   iStall        freezes the sequencer, suppresses all pulse outputs
//   iFlagZ        Z flag for conditional EOF codes
//   iIrqReq/iIme  pending interrupt / interrupt master enable
//   oLutMop       byte presented to main and CB lookup tables
//   iFlowIdx      main table result (flow start index)
//   iCbFlowIdx    CB table result
//   oUopAddr      microcode ROM address (uPC)
//   iUop          ROM word: [12:9] flow code, [8:4] operation, [3:0] operand
//   oUopValid     current ROM word is being executed this cycle
//   oPcInc        increment architectural PC
//   oFlagsUpdate  commit flags
//   oInstrDone    instruction retires this cycle
//   oFetchReq     sequencer is waiting for an opcode
//   oIrqAck       interrupt acknowledge pulse
//   oUopOverrun   sticky: a flow ran off the end of the ROM
// ---------------------------------------------------------------------------
module dzcpu_uop_sequencer #(
    parameter logic [7:0] IRQ_FLOW_IDX = 8'd211,
    parameter logic [4:0] JCB_OPCODE   = 5'h1F
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [7:0]  iMemData,
    input  logic        iFetchValid,
    input  logic        iStall,
    input  logic        iFlagZ,
    input  logic        iIrqReq,
    input  logic        iIme,
    output logic [7:0]  oLutMop,
    input  logic [7:0]  iFlowIdx,
    input  logic [7:0]  iCbFlowIdx,
    output logic [7:0]  oUopAddr,
    input  logic [12:0] iUop,
    output logic        oUopValid,
    output logic        oPcInc,
    output logic        oFlagsUpdate,
    output logic        oInstrDone,
    output logic        oFetchReq,
    output logic        oIrqAck,
    output logic        oUopOverrun
);

`ifdef DZCPU_SEQ_IRQ_EN
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_IRQ = 2'd2} state_e;
`else
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1} state_e;
`endif

    state_e     state_q, state_d;
    logic [7:0] upc_q, upc_d;
    logic       overrun_q, overrun_d;

    logic [3:0] flow_code;
    logic [4:0] uop_op;
    logic       in_exec, flow_eof, overrun_hit, eof, is_jcb, irq_take;

    assign flow_code = iUop[12:9];
    assign uop_op    = iUop[8:4];
    assign in_exec   = (state_q == S_EXEC);

    always_comb begin
        flow_eof = 1'b0;
        case (flow_code)
            4'd2, 4'd3, 4'd4, 4'd5: flow_eof = 1'b1;
            4'd6:                   flow_eof = iFlagZ;
            4'd7:                   flow_eof = ~iFlagZ;
            default:                flow_eof = 1'b0;  // 0,1,8 and 9-15 continue
        endcase
    end

    // Running off the last ROM word must retire rather than wrap to 0.
    assign overrun_hit = (upc_q == 8'hFF) && !flow_eof;
    assign eof         = flow_eof | overrun_hit;
    assign is_jcb      = (uop_op == JCB_OPCODE) && !eof;

`ifdef DZCPU_SEQ_IRQ_EN
    assign irq_take = iIrqReq & iIme;
    assign oIrqAck  = (state_q == S_IRQ) && !iStall;
    logic unused_ok;
    assign unused_ok = ^iUop[3:0];
`else
    assign irq_take = 1'b0;
    assign oIrqAck  = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{iUop[3:0], iIrqReq, iIme, IRQ_FLOW_IDX};
`endif

    assign oUopValid    = in_exec && !iStall;
    assign oPcInc       = oUopValid && (flow_code inside {4'd1, 4'd3, 4'd5, 4'd6, 4'd7});
    assign oFlagsUpdate = oUopValid && (flow_code inside {4'd4, 4'd5, 4'd8});
    assign oInstrDone   = oUopValid && eof;
    assign oFetchReq    = (state_q == S_FETCH);
    assign oUopAddr     = upc_q;
    assign oUopOverrun  = overrun_q;
    // The tables only need the memory byte when an index is being looked up.
    assign oLutMop      = (oFetchReq || (in_exec && is_jcb)) ? iMemData : 8'h00;

    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        overrun_d = overrun_q;
        if (!iStall) begin
            case (state_q)
                S_FETCH: begin
                    if (iFetchValid) begin
                        upc_d   = iFlowIdx;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (eof) begin
`ifdef DZCPU_SEQ_IRQ_EN
                        state_d = irq_take ? S_IRQ : S_FETCH;
`else
                        state_d = irq_take ? S_EXEC : S_FETCH;
`endif
                        if (overrun_hit) overrun_d = 1'b1;
                    end else if (is_jcb) begin
                        upc_d = iCbFlowIdx;
                    end else begin
                        upc_d = upc_q + 8'd1;
                    end
                end
`ifdef DZCPU_SEQ_IRQ_EN
                S_IRQ: begin
                    upc_d   = IRQ_FLOW_IDX;
                    state_d = S_EXEC;
                end
`endif
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q   <= S_FETCH;
            upc_q     <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            upc_q     <= upc_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
module tb_dzcpu_uop_sequencer;

    localparam logic [4:0] JCB     = 5'h1F;
    localparam logic [7:0] IRQ_IDX = 8'd211;
    localparam int         NOSTALL = -1;

    logic        iClock = 1'b0;
    logic        iReset, iFetchValid, iStall, iFlagZ, iIrqReq, iIme;
    logic [7:0]  iMemData, oLutMop, iFlowIdx, iCbFlowIdx, oUopAddr;
    logic [12:0] iUop;
    logic        oUopValid, oPcInc, oFlagsUpdate, oInstrDone, oFetchReq, oIrqAck, oUopOverrun;

    logic [12:0] rom      [256];
    logic [7:0]  main_lut [256];
    logic [7:0]  cb_lut   [256];

    int vectors = 0;
    int miscompares = 0;

    // expected per-uop trace of one flow
    logic [7:0] ea[$];
    bit         ep[$], ef[$], ed[$];

    always #5 iClock = ~iClock;

    assign iUop       = rom[oUopAddr];
    assign iFlowIdx   = main_lut[oLutMop];
    assign iCbFlowIdx = cb_lut[oLutMop];

    dzcpu_uop_sequencer dut (
        .iClock(iClock), .iReset(iReset), .iMemData(iMemData), .iFetchValid(iFetchValid),
        .iStall(iStall), .iFlagZ(iFlagZ), .iIrqReq(iIrqReq), .iIme(iIme),
        .oLutMop(oLutMop), .iFlowIdx(iFlowIdx), .iCbFlowIdx(iCbFlowIdx),
        .oUopAddr(oUopAddr), .iUop(iUop), .oUopValid(oUopValid), .oPcInc(oPcInc),
        .oFlagsUpdate(oFlagsUpdate), .oInstrDone(oInstrDone), .oFetchReq(oFetchReq),
        .oIrqAck(oIrqAck), .oUopOverrun(oUopOverrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge iClock);
        #1;
    endtask

    function automatic logic [12:0] w(input int code, input int op);
        logic [12:0] r;
        r = {4'(code), 5'(op), 4'd0};
        return r;
    endfunction

    // Walk a flow through the ROM image using the flow-code rules directly.
    task automatic build_trace(input logic [7:0] start, input logic [7:0] cbb, input bit z);
        logic [7:0] a;
        int code, op;
        bit stop;
        ea.delete(); ep.delete(); ef.delete(); ed.delete();
        a = start;
        for (int n = 0; n < 300; n++) begin
            code = int'(rom[a][12:9]);
            op   = int'(rom[a][8:4]);
            stop = (code >= 2 && code <= 5) || (code == 6 && z) || (code == 7 && !z) || (a == 8'hFF);
            ea.push_back(a);
            ep.push_back(code == 1 || code == 3 || code == 5 || code == 6 || code == 7);
            ef.push_back(code == 4 || code == 5 || code == 8);
            ed.push_back(stop);
            if (stop) break;
            a = (op == int'(JCB)) ? cb_lut[cbb] : a + 8'd1;
        end
    endtask

    task automatic run_flow(input logic [7:0] start, input logic [7:0] cbb, input bit z,
                            input int stall_at, input int stall_n, input int pct);
        int ns;
        build_trace(start, cbb, z);
        iMemData = cbb; iFlagZ = z; iFetchValid = 1'b0;
        foreach (ea[i]) begin
            ns = (int'(ea[i]) == stall_at) ? stall_n : (($urandom_range(0, 99) < pct) ? 1 : 0);
            repeat (ns) begin
                iStall = 1'b1; #1;
                chk("stall_addr", oUopAddr, ea[i]);
                chk("stall_vld", oUopValid, 0);
                chk("stall_pcinc", oPcInc, 0);
                chk("stall_done", oInstrDone, 0);
                cyc();
            end
            iStall = 1'b0; #1;
            chk("uop_addr", oUopAddr, ea[i]);
            chk("uop_vld", oUopValid, 1);
            chk("pc_inc", oPcInc, ep[i]);
            chk("flags_upd", oFlagsUpdate, ef[i]);
            chk("instr_done", oInstrDone, ed[i]);
            cyc();
        end
    endtask

    task automatic run_instr(input logic [7:0] opc, input logic [7:0] cbb, input bit z,
                             input int stall_at, input int stall_n, input int pct, input bit fstall);
        iMemData = opc; iFetchValid = 1'b1;
        if (fstall) begin
            iStall = 1'b1; #1;
            chk("fstall_req", oFetchReq, 1);
            cyc();
        end
        iStall = 1'b0; #1;
        chk("fetch_req", oFetchReq, 1);
        chk("lut_mop", oLutMop, opc);
        cyc();
        run_flow(main_lut[opc], cbb, z, stall_at, stall_n, pct);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = w(2, 0); main_lut[i] = 8'd0; cb_lut[i] = 8'd0;
        end
        rom[0] = w(0, 0);
        main_lut[8'h31] = 8'd1;
        rom[1] = w(1, 0); rom[2] = w(1, 3); rom[3] = w(0, 5); rom[4] = w(3, 0);
        main_lut[8'hCB] = 8'd13; cb_lut[8'h7C] = 8'd16;
        rom[13] = w(0, 1); rom[14] = w(0, 2); rom[15] = w(0, int'(JCB)); rom[16] = w(4, 0);
        main_lut[8'h20] = 8'd19;
        rom[19] = w(6, 0); rom[20] = w(1, 0); rom[21] = w(0, 0); rom[22] = w(2, 0);
        main_lut[8'h77] = 8'hFE; rom[8'hFE] = w(0, 0); rom[8'hFF] = w(9, 0);
        rom[IRQ_IDX] = w(1, 0); rom[IRQ_IDX + 8'd1] = w(2, 0);
        for (int k = 0; k < 16; k++) begin
            int base, r, code;
            base = 40 + k * 10;
            main_lut[8'h80 + k] = 8'(base);
            for (int j = 0; j < 9; j++) begin
                r = $urandom_range(0, 9);
                code = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 6 : (r == 3) ? 7 : (r == 4) ? 8 : 4 + r;
                rom[base + j] = w(code, $urandom_range(0, 30));
            end
            rom[base + 9] = w(2 + $urandom_range(0, 3), $urandom_range(0, 30));
        end

        iReset = 1'b0; iFetchValid = 1'b0; iStall = 1'b0; iFlagZ = 1'b0;
        iIrqReq = 1'b0; iIme = 1'b0; iMemData = 8'h00;
        cyc(); cyc();
        chk("rst_addr", oUopAddr, 0);
        chk("rst_fetch", oFetchReq, 1);
        chk("rst_vld", oUopValid, 0);
        chk("rst_done", oInstrDone, 0);
        chk("rst_ovr", oUopOverrun, 0);
        chk("rst_ack", oIrqAck, 0);
        iReset = 1'b1;

        run_instr(8'h31, 8'h00, 1'b0, NOSTALL, 0, 0, 1'b0);
        run_instr(8'hCB, 8'h7C, 1'b0, NOSTALL, 0, 0, 1'b0);
        run_instr(8'h20, 8'h00, 1'b1, NOSTALL, 0, 0, 1'b0);
        run_instr(8'h20, 8'h00, 1'b0, 20, 3, 0, 1'b0);
        run_instr(8'h05, 8'h00, 1'b0, NOSTALL, 0, 0, 1'b1);
        chk("no_ovr", oUopOverrun, 0);
        run_instr(8'h77, 8'h00, 1'b0, NOSTALL, 0, 0, 1'b0);
        chk("ovr_set", oUopOverrun, 1);
        run_instr(8'h31, 8'h00, 1'b0, NOSTALL, 0, 0, 1'b0);
        chk("ovr_sticky", oUopOverrun, 1);

        // reset in the middle of a flow
        iMemData = 8'h20; iFetchValid = 1'b1; iFlagZ = 1'b0; #1;
        cyc();
        iFetchValid = 1'b0; iMemData = 8'h00; #1;
        chk("mid_19", oUopAddr, 19); cyc();
        chk("mid_20", oUopAddr, 20); cyc();
        chk("mid_21", oUopAddr, 21);
        iReset = 1'b0;
        cyc();
        chk("mid_rst_addr", oUopAddr, 0);
        chk("mid_rst_fetch", oFetchReq, 1);
        chk("mid_rst_vld", oUopValid, 0);
        chk("mid_rst_ovr", oUopOverrun, 0);
        iReset = 1'b1;

        // interrupt request without IME never diverts
        iIrqReq = 1'b1; iIme = 1'b0;
        run_instr(8'h31, 8'h00, 1'b0, NOSTALL, 0, 0, 1'b0);
        iIrqReq = 1'b0; #1;
        chk("noime_fetch", oFetchReq, 1);
        chk("noime_ack", oIrqAck, 0);

        iIrqReq = 1'b1; iIme = 1'b1;
        run_instr(8'h31, 8'h00, 1'b0, NOSTALL, 0, 0, 1'b0);
        iIrqReq = 1'b0; iIme = 1'b0; #1;
`ifdef DZCPU_SEQ_IRQ_EN
        chk("irq_ack", oIrqAck, 1);
        chk("irq_nofetch", oFetchReq, 0);
        chk("irq_vld", oUopValid, 0);
        cyc();
        chk("irq_ack_pulse", oIrqAck, 0);
        run_flow(IRQ_IDX, 8'h00, 1'b0, NOSTALL, 0, 0);
        #1;
        chk("irq_end_fetch", oFetchReq, 1);
`else
        chk("irq_off_ack", oIrqAck, 0);
        chk("irq_off_fetch", oFetchReq, 1);
`endif

        for (int t = 0; t < 40; t++) begin
            logic [7:0] opc;
            opc = (t % 8 == 7) ? 8'h20 : 8'(8'h80 + $urandom_range(0, 15));
            run_instr(opc, 8'(t), 1'($urandom_range(0, 1)), NOSTALL, 0, 25, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
